// File: rtl/line_follow_pkg.sv
// line_follow_pkg: shared steer encodings, channel numbers and sample width
package line_follow_pkg;
  localparam int SAMPLE_W = 12;
  localparam logic [2:0] CH_LEFT = 3'd5;
  localparam logic [2:0] CH_CENTER = 3'd6;
  localparam logic [2:0] CH_RIGHT = 3'd7;
  typedef enum logic [1:0] {
    STEER_FWD = 2'b00,
    STEER_LEFT = 2'b01,
    STEER_RIGHT = 2'b10,
    STEER_LOST = 2'b11
  } steer_t;
  function automatic steer_t steer_target(input logic [2:0] p, input steer_t cur);
    return (p == 3'b010 || p == 3'b111) ? STEER_FWD :
           (p == 3'b100 || p == 3'b110) ? STEER_LEFT :
           (p == 3'b001 || p == 3'b011) ? STEER_RIGHT : cur;
  endfunction
endpackage

// File: rtl/sensor_channel_filter.sv
// sensor_channel_filter: hysteresis threshold plus per-frame debounce of one sensor
module sensor_channel_filter
  import line_follow_pkg::*;
#(
  parameter logic [SAMPLE_W-1:0] THRESH_HI = 12'd2000,
  parameter logic [SAMPLE_W-1:0] THRESH_LO = 12'd1500,
  parameter int unsigned DEBOUNCE = 2
) (
  input  logic                clk_50,
  input  logic                rst_n,
  input  logic                sample_strobe,
  input  logic [SAMPLE_W-1:0] sample_data,
  input  logic                frame_ready,
  output logic                line
);
  logic       raw;
  logic [3:0] cnt;
  always_ff @(posedge clk_50) begin
    if (!rst_n) begin
      raw <= 1'b0;
      cnt <= 4'd0;
      line <= 1'b0;
    end else begin
      if (sample_strobe)
        raw <= (sample_data >= THRESH_HI) ? 1'b1 : (sample_data <= THRESH_LO) ? 1'b0 : raw;
      if (frame_ready) begin
        cnt <= (raw != line && cnt + 4'd1 != 4'(DEBOUNCE)) ? cnt + 4'd1 : 4'd0;
        line <= (raw != line && cnt + 4'd1 == 4'(DEBOUNCE)) ? ~line : line;
      end
    end
  end
endmodule

// File: rtl/line_sensor_decoder.sv
// line_sensor_decoder: frame assembly, steering FSM, node detect and stale watchdog
module line_sensor_decoder
  import line_follow_pkg::*;
#(
  parameter logic [SAMPLE_W-1:0] THRESH_HI = 12'd2000,
  parameter logic [SAMPLE_W-1:0] THRESH_LO = 12'd1500,
  parameter int unsigned DEBOUNCE = 2,
  parameter int unsigned LOST_FRAMES = 4,
  parameter int unsigned TIMEOUT = 200000
) (
  input  logic                clk_50,
  input  logic                rst_n,
  input  logic                sample_valid,
  input  logic [2:0]          sample_ch,
  input  logic [SAMPLE_W-1:0] sample_data,
  output logic                line_l,
  output logic                line_c,
  output logic                line_r,
  output logic [1:0]          steer,
  output logic                frame_done,
  output logic                node_pulse,
  output logic [7:0]          node_count,
  output logic                stale
);
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [2:0]    mask, nmask, hit, deb, pat;
  logic          frame_ready, fr_d, prev_node, node_hit;
  logic [3:0]    lost, lost_n;
  logic [TW-1:0] tcnt;
  steer_t        state;
  always_comb begin
    hit = (sample_valid && sample_ch >= CH_LEFT) ? 3'b001 << (sample_ch - CH_LEFT) : 3'b000;
    nmask = mask | hit;
    pat = {deb[0], deb[1], deb[2]};
    lost_n = (lost == 4'(LOST_FRAMES)) ? lost : lost + 4'd1;
    node_hit = pat == 3'b111 && !prev_node;
  end
  for (genvar i = 0; i < 3; i++) begin : g_ch
    sensor_channel_filter #(
      .THRESH_HI(THRESH_HI),
      .THRESH_LO(THRESH_LO),
      .DEBOUNCE(DEBOUNCE)
    ) u_filt (
      .clk_50(clk_50),
      .rst_n(rst_n),
      .sample_strobe(hit[i]),
      .sample_data(sample_data),
      .frame_ready(frame_ready),
      .line(deb[i])
    );
  end
  always_ff @(posedge clk_50) begin
    if (!rst_n) begin
      mask <= 3'b000;
      frame_ready <= 1'b0;
      fr_d <= 1'b0;
      frame_done <= 1'b0;
      node_pulse <= 1'b0;
      node_count <= 8'd0;
      prev_node <= 1'b0;
      {line_l, line_c, line_r} <= 3'b000;
      state <= STEER_FWD;
      lost <= 4'd0;
      tcnt <= '0;
    end else begin
      mask <= (nmask == 3'b111) ? 3'b000 : nmask;
      frame_ready <= nmask == 3'b111;
      fr_d <= frame_ready;
      frame_done <= fr_d;
      node_pulse <= fr_d && node_hit;
      tcnt <= frame_ready ? '0 : stale ? tcnt : tcnt + 1'b1;
      if (fr_d) begin
        {line_l, line_c, line_r} <= pat;
        prev_node <= pat == 3'b111;
        lost <= (pat == 3'b000) ? lost_n : 4'd0;
        state <= (pat == 3'b000) ? ((lost_n == 4'(LOST_FRAMES)) ? STEER_LOST : state) : steer_target(pat, state);
        if (node_hit && node_count != 8'hff) node_count <= node_count + 8'd1;
      end
    end
  end
  assign stale = tcnt == TW'(TIMEOUT);
  assign steer = stale ? STEER_LOST : state;
endmodule

// File: tb/tb_line_sensor_decoder.sv
// tb_line_sensor_decoder: directed and random stimulus against a frame-level reference model
module tb_line_sensor_decoder;
  localparam int HI = 2000, LO = 1500, DB = 2, LF = 4, TO = 50;
  logic clk_50 = 1'b0, rst_n = 1'b0, sample_valid = 1'b0;
  logic [2:0] sample_ch = 3'd0;
  logic [11:0] sample_data = 12'd0;
  logic line_l, line_c, line_r, frame_done, node_pulse, stale;
  logic [1:0] steer;
  logic [7:0] node_count;
  int total = 0, passed = 0;
  string phase = "reset";
  bit raw[3], deb[3], got[3];
  int dcnt[3];
  int lostc, fsm, nodes, since, due;
  bit prev111, fr_prev, p_node, e_done, e_node;
  logic [2:0] p_line, e_line;
  logic [1:0] p_fsm, e_fsm;
  logic [7:0] p_nodes, e_nodes;
  line_sensor_decoder #(
    .THRESH_HI(12'(HI)),
    .THRESH_LO(12'(LO)),
    .DEBOUNCE(DB),
    .LOST_FRAMES(LF),
    .TIMEOUT(TO)
  ) dut (
    .clk_50(clk_50),
    .rst_n(rst_n),
    .sample_valid(sample_valid),
    .sample_ch(sample_ch),
    .sample_data(sample_data),
    .line_l(line_l),
    .line_c(line_c),
    .line_r(line_r),
    .steer(steer),
    .frame_done(frame_done),
    .node_pulse(node_pulse),
    .node_count(node_count),
    .stale(stale)
  );
  always #10 clk_50 = ~clk_50;
  // Frame-level model: a completed frame's results appear two edges after the completing sample.
  task automatic model_edge(input logic r, input logic v, input logic [2:0] c, input logic [11:0] d);
    int i;
    logic [2:0] p;
    if (!r) begin
      for (int k = 0; k < 3; k++) begin
        raw[k] = 0; deb[k] = 0; dcnt[k] = 0; got[k] = 0;
      end
      lostc = 0; fsm = 0; prev111 = 0; nodes = 0; since = 0; fr_prev = 0; due = 0;
      e_line = 0; e_fsm = 0; e_nodes = 0; e_done = 0; e_node = 0;
      return;
    end
    e_done = 0;
    e_node = 0;
    if (due > 0) begin
      due--;
      if (due == 0) begin
        e_line = p_line; e_fsm = p_fsm; e_nodes = p_nodes; e_done = 1; e_node = p_node;
      end
    end
    since = fr_prev ? 0 : (since < TO ? since + 1 : TO);
    fr_prev = 0;
    if (v && c >= 3'd5) begin
      i = int'(c) - 5;
      if (int'(d) >= HI) raw[i] = 1;
      else if (int'(d) <= LO) raw[i] = 0;
      got[i] = 1;
      if (got[0] && got[1] && got[2]) begin
        for (int k = 0; k < 3; k++) got[k] = 0;
        fr_prev = 1;
        due = 2;
        for (int k = 0; k < 3; k++) begin
          if (raw[k] != deb[k]) begin
            dcnt[k]++;
            if (dcnt[k] == DB) begin deb[k] = !deb[k]; dcnt[k] = 0; end
          end else dcnt[k] = 0;
        end
        p = {deb[0], deb[1], deb[2]};
        p_node = (p == 3'b111) && !prev111;
        prev111 = p == 3'b111;
        if (p_node && nodes < 255) nodes++;
        if (p == 3'b000) begin
          if (lostc < LF) lostc++;
          if (lostc == LF) fsm = 3;
        end else begin
          lostc = 0;
          if (p == 3'b010 || p == 3'b111) fsm = 0;
          else if (p == 3'b100 || p == 3'b110) fsm = 1;
          else if (p == 3'b001 || p == 3'b011) fsm = 2;
        end
        p_line = p; p_fsm = 2'(fsm); p_nodes = 8'(nodes);
      end
    end
  endtask
  task automatic tick(input logic r, input logic v, input logic [2:0] c, input logic [11:0] d);
    logic [15:0] obs, exp;
    rst_n = r; sample_valid = v; sample_ch = c; sample_data = d;
    @(posedge clk_50);
    model_edge(r, v, c, d);
    #1;
    obs = {line_l, line_c, line_r, steer, frame_done, node_pulse, node_count, stale};
    exp = {e_line, (since == TO) ? 2'd3 : e_fsm, e_done, e_node, e_nodes, since == TO};
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s t=%0t observed lcr/steer/done/node/cnt/stale=%h expected=%h", phase, $time, obs, exp);
  endtask
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(1'b1, 1'b0, 3'd0, 12'd0);
  endtask
  task automatic frame(input int l, input int c, input int r, input int gap);
    int s, ch;
    s = $urandom_range(0, 2);
    for (int k = 0; k < 3; k++) begin
      ch = 5 + (s + k) % 3;
      tick(1'b1, 1'b1, 3'(ch), 12'(ch == 5 ? l : ch == 6 ? c : r));
    end
    idle(gap);
  endtask
  function automatic logic [11:0] rnd_data();
    case ($urandom_range(0, 5))
      0: return 12'($urandom_range(0, 4095));
      1: return 12'(HI - 1 + $urandom_range(0, 2));
      2: return 12'(LO - 1 + $urandom_range(0, 2));
      3: return 12'd2500;
      4: return 12'd100;
      default: return 12'd1750;
    endcase
  endfunction
  initial begin
    for (int k = 0; k < 3; k++) tick(1'b0, k[0], 3'd6, 12'd4095);
    phase = "hysteresis";
    for (int k = 0; k < 2; k++) frame(100, 2100, 100, 1);
    frame(100, 1800, 100, 1);
    for (int k = 0; k < 2; k++) frame(100, 1400, 100, 1);
    for (int k = 0; k < 5; k++) frame(100, 100, 100, 1);
    phase = "debounce";
    frame(2500, 100, 100, 1);
    frame(100, 100, 100, 1);
    frame(2500, 100, 100, 1);
    frame(2500, 100, 100, 2);
    phase = "assembly";
    tick(1'b1, 1'b1, 3'd7, 12'd100);
    tick(1'b1, 1'b1, 3'd3, 12'd4095);
    tick(1'b1, 1'b1, 3'd7, 12'd2500);
    tick(1'b1, 1'b1, 3'd5, 12'd100);
    tick(1'b1, 1'b1, 3'd6, 12'd100);
    idle(4);
    phase = "node";
    for (int k = 0; k < 2; k++) frame(100, 2500, 100, 0);
    for (int k = 0; k < 3; k++) frame(2500, 2500, 2500, 0);
    for (int k = 0; k < 2; k++) frame(100, 2500, 100, 0);
    phase = "timeout";
    idle(55);
    frame(100, 2500, 100, 3);
    phase = "midreset";
    tick(1'b1, 1'b1, 3'd5, 12'd2500);
    tick(1'b1, 1'b1, 3'd6, 12'd2500);
    tick(1'b0, 1'b1, 3'd7, 12'd2500);
    tick(1'b1, 1'b1, 3'd7, 12'd2500);
    idle(4);
    phase = "random";
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) idle(60);
      else tick($urandom_range(0, 499) != 0, $urandom_range(0, 2) != 0,
                $urandom_range(0, 3) == 0 ? 3'($urandom_range(0, 7)) : 3'(5 + $urandom_range(0, 2)),
                rnd_data());
    end
    phase = "saturate";
    for (int n = 0; n < 260; n++) begin
      for (int k = 0; k < 2; k++) frame(2500, 2500, 2500, 0);
      for (int k = 0; k < 2; k++) frame(100, 2500, 100, 0);
    end
    idle(3);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/line_sensor_decoder.md
Name: line_sensor_decoder

Overview:
- Consumes per-channel 12-bit conversions from the ADC128S022 serial front end: left sensor ch5, centre ch6, right sensor ch7.
- Thresholds each channel with hysteresis, assembles a 3-channel frame and debounces each flag across frames.
- Drives a steering-state FSM plus node-detect and stale-data outputs for the motor/LED stage downstream.

Parameters:
- THRESH_HI, 12'd2000, raw flag sets (on line) when sample >= THRESH_HI
- THRESH_LO, 12'd1500, raw flag clears when sample <= THRESH_LO; THRESH_LO < THRESH_HI is required
- DEBOUNCE, 2, consecutive frames a raw flag must differ from the debounced flag before the debounced flag changes (range 1..15)
- LOST_FRAMES, 4, consecutive all-off debounced frames before steer goes LOST (range 1..15)
- TIMEOUT, 200000, clk_50 cycles without a completed frame before stale asserts

Ports:
- clk_50  in  1  50 MHz system clock
- rst_n  in  1  reset; synchronous, active-low
- sample_valid  in  1  one-cycle strobe: sample_ch/sample_data valid
- sample_ch  in  3  ADC channel number of the sample
- sample_data  in  12  conversion result
- line_l / line_c / line_r  out  1 each  debounced on-line flags (ch5/ch6/ch7)
- steer  out  2  00 FWD, 01 LEFT, 10 RIGHT, 11 LOST
- frame_done  out  1  one-cycle pulse when outputs are updated for a new frame
- node_pulse  out  1  one-cycle pulse on node entry
- node_count  out  8  nodes seen, saturates at 255
- stale  out  1  no frame completed within TIMEOUT cycles

Behaviour:
- Reset (rst_n low at a clk_50 edge): all outputs 0, steer = FWD, raw flags 0, received mask 0, all counters 0. Reset wins over any same-cycle sample_valid.
- Stage 1, sample accept:
  - On sample_valid with sample_ch in {5,6,7}, update that channel's raw flag: set if data >= THRESH_HI; clear if data <= THRESH_LO; otherwise hold.
  - Set that channel's bit in the received mask.
  - Samples from other channels are ignored: no flag or mask change.
- Frame completion:
  - When the accepted sample makes the mask 3'b111, the mask clears at that same edge and an internal frame_ready registers.
  - A duplicate channel before completion re-evaluates that flag and does not complete the frame.
  - Arrival order is irrelevant.
- Stage 2, one edge after frame_ready:
  - Per channel: if raw != debounced, increment that channel's counter; when it reaches DEBOUNCE, toggle the debounced flag and zero the counter. If raw == debounced, zero the counter.
  - The steer FSM updates in the same edge, using the new debounced pattern (l,c,r).
  - frame_done pulses in the cycle after this edge.
- Latency: sample completing a frame accepted at edge t -> updated line_*/steer/frame_done visible after edge t+2.
- Steer FSM, evaluated only on frame updates:
  - 010 or 111 -> FWD
  - 100 or 110 -> LEFT
  - 001 or 011 -> RIGHT
  - 101 -> hold state
  - 000 -> increment lost counter (saturating); when it reaches LOST_FRAMES -> LOST, else hold state
  - Any non-000 pattern clears the lost counter.
  - LOST exits immediately on any pattern with a defined target.
- Node detect:
  - node_pulse fires (same cycle as frame_done) when the pattern is 111 and the previous frame's pattern was not 111.
  - node_count increments on the pulse, saturating at 255.
  - A continuous 111 gives one pulse.
- Timeout:
  - The cycle counter clears on every frame_ready and saturates at TIMEOUT; stale = (count == TIMEOUT).
  - While stale, steer is forced to LOST; line_* hold their values.
  - The next completed frame clears stale immediately; steer then takes its FSM value from that frame's update.
- Mid-frame reset discards the partial frame; the first frame after reset needs all three channels again.

Decomposition:
- Shared package (line_follow_pkg):
  - steer encodings STEER_FWD / LEFT / RIGHT / LOST
  - channel constants CH_LEFT=5, CH_CENTER=6, CH_RIGHT=7
  - 12-bit sample width constant
- Natural sub-module: sensor_channel_filter, instantiated 3x. It holds the hysteresis raw flag, debounce counter and debounced flag. Inputs: sample strobe, data, frame_ready. Output: debounced flag.

Test Plan:
- Reset: rst_n=0 for 3 cycles with sample_valid toggling -> all outputs 0, steer=00, no frame_done.
- Hysteresis: ch6 samples 2100, 1800, 1400 with ch5/ch7 = 100, one frame each, DEBOUNCE=1 -> line_c 1, 1, 0; steer FWD, FWD, then LOST only after 4 more all-off frames.
- Debounce: ch5 = 2500 for one frame then 100 (DEBOUNCE=2) -> line_l stays 0. Two consecutive 2500 frames -> line_l=1 at the second frame_done, steer=LEFT.
- Frame assembly: ch7, ch3 (=4095), ch7, ch5, ch6 -> exactly one frame_done, 2 cycles after the ch6 strobe; ch3 has no effect.
- Node: frames 010, 111, 111, 010 -> one node_pulse (second frame), node_count=1, steer FWD throughout. Preload 255 nodes -> count holds 255.
- Timeout (TIMEOUT=50): complete one frame, then no samples for 50 cycles -> stale=1, steer=11. Next completed 010 frame -> stale=0, steer=00.
